// File: rtl/ir_tx_multi.sv
// ir_tx_multi: bus-mapped IR remote transmitter with a shared packet engine and a 4-colour timing table
module ir_tx_multi #(
  parameter logic [7:0]  BASE_ADDR = 8'h90,
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          PACKET_HZ = 10,
  parameter int          CMD_BITS  = 4,
  parameter logic [43:0] RATIO     = {11'd1334, 11'd1389, 11'd1389, 11'd1250}
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] ADDR_IN,
  input  logic       BUS_WE,
  input  logic [7:0] DATA_IN,
  output logic       IR_LED,
  output logic       BUSY,
  output logic       PKT_DONE
);
  localparam int TICK = CLK_HZ / PACKET_HZ;
  localparam int RW = $clog2(TICK);
  localparam logic [7:0] CMD_MASK = 8'((2 ** CMD_BITS) - 1);
  // per-colour tables, yellow in the low byte, green in the high byte
  localparam logic [31:0] START_T = {8'd88, 8'd192, 8'd191, 8'd88};
  localparam logic [31:0] SEL_T   = {8'd44, 8'd24, 8'd47, 8'd22};
  localparam logic [31:0] GAP_T   = {8'd40, 8'd24, 8'd25, 8'd40};
  localparam logic [31:0] AS_T    = {8'd44, 8'd48, 8'd47, 8'd44};
  localparam logic [31:0] DE_T    = {8'd22, 8'd24, 8'd22, 8'd22};
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t state;
  logic [7:0] cmd, sh, off, cnt, first_len, gap_len, nxt_len;
  logic [1:0] colour, col_s, mode;
  logic [RW-1:0] rate;
  logic [10:0] pc, pc_nxt, ratio, half;
  logic [3:0] seg;
  logic pend, hit, trig, tick, req, pc_end, seg_end, last;
  assign off = ADDR_IN - BASE_ADDR;
  assign hit = BUS_WE && off[7:2] == 6'd0;
  assign trig = hit && off[1:0] == 2'd3;
  assign tick = rate == RW'(TICK - 1);
  assign req = trig || pend || (tick && mode == 2'b11);
  assign ratio = RATIO[11 * col_s +: 11];
  assign half = ratio >> 1;
  assign pc_end = pc == ratio - 11'd1;
  assign pc_nxt = pc_end ? 11'd0 : pc + 11'd1;
  assign seg_end = pc_end && cnt == 8'd0;
  assign last = seg == 4'(CMD_BITS + 1);
  assign first_len = START_T[{colour, 3'b0} +: 8];
  assign gap_len = GAP_T[{col_s, 3'b0} +: 8];
  // sh[0] always holds the command bit of the next BIT segment
  assign nxt_len = seg == 4'd0 ? SEL_T[{col_s, 3'b0} +: 8] :
                   sh[0] ? AS_T[{col_s, 3'b0} +: 8] : DE_T[{col_s, 3'b0} +: 8];
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cmd <= '0;
      sh <= '0;
      colour <= '0;
      col_s <= '0;
      mode <= '0;
      rate <= '0;
      pc <= '0;
      cnt <= '0;
      seg <= '0;
      pend <= 1'b0;
      IR_LED <= 1'b0;
      BUSY <= 1'b0;
      PKT_DONE <= 1'b0;
    end else begin
      if (hit && off[1:0] == 2'd0) cmd <= DATA_IN & CMD_MASK;
      if (hit && off[1:0] == 2'd1) colour <= DATA_IN[1:0];
      if (hit && off[1:0] == 2'd2) mode <= DATA_IN[1:0];
      rate <= tick ? '0 : rate + RW'(1);
      pend <= state != IDLE && (pend || trig);
      PKT_DONE <= 1'b0;
      case (state)
        IDLE: begin
          IR_LED <= 1'b0;
          if (req) begin
            state <= BURST;
            BUSY <= 1'b1;
            IR_LED <= 1'b1;
            pc <= '0;
            cnt <= first_len - 8'd1;
            seg <= '0;
            col_s <= colour;
            sh <= cmd;
          end
        end
        BURST: begin
          pc <= pc_nxt;
          if (seg_end) begin
            state <= GAP;
            cnt <= gap_len - 8'd1;
            IR_LED <= 1'b0;
          end else begin
            if (pc_end) cnt <= cnt - 8'd1;
            IR_LED <= pc_nxt < half;
          end
        end
        default: begin
          pc <= pc_nxt;
          if (seg_end && last) begin
            state <= IDLE;
            BUSY <= 1'b0;
            PKT_DONE <= 1'b1;
          end else if (seg_end) begin
            state <= BURST;
            seg <= seg + 4'd1;
            cnt <= nxt_len - 8'd1;
            IR_LED <= 1'b1;
            if (seg != 4'd0) sh <= sh >> 1;
          end else if (pc_end) begin
            cnt <= cnt - 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ir_tx_multi.sv
// tb_ir_tx_multi: directed bench for ir_tx_multi with shortened carrier ratios and tick period
module tb_ir_tx_multi;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BUS_WE = 1'b0;
  logic [7:0] ADDR_IN = 8'h00;
  logic [7:0] DATA_IN = 8'h00;
  logic IR_LED, BUSY, PKT_DONE;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, quiet;
  int p_n, p_rise, p_hi, p_first, p_h1, p_l1, p_dn;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // ratios: yellow 12, blue 14, red 13, green 14; one rate tick every 8000 clocks
  ir_tx_multi #(
    .BASE_ADDR(8'h90),
    .CLK_HZ(8000),
    .PACKET_HZ(1),
    .CMD_BITS(4),
    .RATIO({11'd14, 11'd13, 11'd14, 11'd12})
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ADDR_IN(ADDR_IN),
    .BUS_WE(BUS_WE),
    .DATA_IN(DATA_IN),
    .IR_LED(IR_LED),
    .BUSY(BUSY),
    .PKT_DONE(PKT_DONE)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    ADDR_IN = a;
    DATA_IN = d;
    BUS_WE = 1'b1;
    @(posedge CLK);
    #1;
    BUS_WE = 1'b0;
  endtask
  task automatic wait_busy(input int lim);
    int n = 0;
    while (BUSY !== 1'b1 && n < lim) begin
      step(1);
      n++;
    end
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while (BUSY !== 1'b0 && n < lim) begin
      step(1);
      n++;
    end
  endtask
  task automatic count_busy(input int k, output int c);
    c = 0;
    for (int i = 0; i < k; i++) begin
      step(1);
      if (BUSY !== 1'b0) c++;
    end
  endtask
  // Walks one packet from its first BUSY sample to the PKT_DONE sample, profiling IR_LED.
  task automatic pkt(input int lim);
    int lowrun = 0;
    int ph = 0;
    logic prev = 1'b0;
    p_n = 0; p_rise = 0; p_hi = 0; p_first = 0; p_h1 = 0; p_l1 = 0; p_dn = 0;
    while (BUSY === 1'b1 && p_n < lim) begin
      p_n++;
      if (IR_LED === 1'b1) begin
        p_hi++;
        if (!prev) p_rise++;
        lowrun = 0;
        if (ph == 1) ph = 2;
        if (ph == 0) p_h1++;
      end else begin
        lowrun++;
        if (lowrun == 16 && p_first == 0) p_first = p_rise;
        if (ph == 0) ph = 1;
        if (ph == 1) p_l1++;
      end
      prev = IR_LED;
      if (PKT_DONE === 1'b1) p_dn++;
      step(1);
    end
  endtask
  initial begin
    step(3);
    @(negedge CLK);
    RST = 1'b0;
    step(1);
    chk("rst_busy", BUSY, 0);
    chk("rst_led", IR_LED, 0);
    chk("rst_done", PKT_DONE, 0);
    // reset in the middle of a packet
    wr(8'h93, 8'h00);
    chk("t1_busy", BUSY, 1);
    chk("t1_led", IR_LED, 1);
    step(30);
    @(negedge CLK);
    RST = 1'b1;
    step(1);
    chk("t1_rst_led", IR_LED, 0);
    chk("t1_rst_busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b0;
    count_busy(200, quiet);
    chk("t1_quiet", quiet, 0);
    // yellow, CMD 1001: 242 burst + 240 gap periods of 12 clocks
    wr(8'h90, 8'h09);
    wr(8'h91, 8'h00);
    wr(8'h93, 8'h00);
    pkt(20000);
    chk("t2_len", p_n, 5784);
    chk("t2_rises", p_rise, 242);
    chk("t2_high", p_hi, 1452);
    chk("t2_first", p_first, 88);
    chk("t2_h1", p_h1, 6);
    chk("t2_l1", p_l1, 6);
    chk("t2_done_early", p_dn, 0);
    chk("t2_done", PKT_DONE, 1);
    chk("t2_end_busy", BUSY, 0);
    step(1);
    chk("t2_done_clr", PKT_DONE, 0);
    count_busy(50, quiet);
    chk("t2_quiet", quiet, 0);
    // red, CMD 0: ratio 13 gives 6 high / 7 low
    wr(8'h91, 8'h02);
    wr(8'h90, 8'h00);
    wr(8'h93, 8'h00);
    pkt(20000);
    chk("t3_len", p_n, 5928);
    chk("t3_rises", p_rise, 312);
    chk("t3_high", p_hi, 1872);
    chk("t3_first", p_first, 192);
    chk("t3_h1", p_h1, 6);
    chk("t3_l1", p_l1, 7);
    chk("t3_done", PKT_DONE, 1);
    // continuous mode: starts 8000 clocks apart, stop after current packet
    wr(8'h91, 8'h00);
    wr(8'h92, 8'h03);
    wait_busy(9000);
    chk("t4_start1", BUSY, 1);
    t0 = cyc;
    wait_idle(9000);
    wait_busy(9000);
    chk("t4_start2", BUSY, 1);
    chk("t4_period", cyc - t0, 8000);
    wr(8'h92, 8'h01);
    wait_idle(9000);
    chk("t4_done", PKT_DONE, 1);
    count_busy(9000, quiet);
    chk("t4_stopped", quiet, 0);
    // three triggers during a packet merge into one extra packet
    wr(8'h93, 8'h00);
    t0 = cyc;
    step(100);
    wr(8'h93, 8'h00);
    wr(8'h93, 8'h00);
    wr(8'h93, 8'h00);
    wait_idle(9000);
    chk("t5_done", PKT_DONE, 1);
    chk("t5_len", cyc - t0, 5256);
    step(1);
    chk("t5_restart", BUSY, 1);
    pkt(9000);
    chk("t5_len2", p_n, 5256);
    count_busy(300, quiet);
    chk("t5_one_extra", quiet, 0);
    // CMD write mid-packet only affects the next packet
    wr(8'h93, 8'h00);
    t0 = cyc;
    step(5);
    wr(8'h90, 8'h0F);
    wr(8'h93, 8'h00);
    wait_idle(9000);
    chk("t6_len", cyc - t0, 5256);
    chk("t6_done", PKT_DONE, 1);
    step(1);
    pkt(9000);
    chk("t6_len2", p_n, 6312);
    chk("t6_rises2", p_rise, 286);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
